text_scroll_ctrl: RTL and testbench



---
 rtl/text_scroll_ctrl.sv | 156 +++++++++++++++
 tb/tb_text_scroll_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/text_scroll_ctrl.sv
// text_scroll_ctrl: scrolls a buffered message across NUM_DIGITS 7-segment digits
// through one shared registered lookup table, committing each frame atomically.
module text_scroll_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_DEPTH  = 16,
  parameter int SCROLL_DIV = 25000000,
  parameter int LUT_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0]  wr_addr,
  input  logic [6:0]                    wr_code,
  input  logic [$clog2(MSG_DEPTH):0]    msg_len,
  input  logic                          loop,
  input  logic                          start,
  input  logic                          stop,
  output logic [6:0]                    lut_code,
  input  logic [6:0]                    lut_seg,
  output logic [7*NUM_DIGITS-1:0]       digit_seg,
  output logic                          frame_valid,
  output logic                          busy,
  output logic                          done
);
  localparam int AW   = $clog2(MSG_DEPTH);
  localparam int DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CMAX = (SCROLL_DIV > NUM_DIGITS) ? SCROLL_DIV : NUM_DIGITS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int SW   = AW + DW + 2;
  localparam int TD   = LUT_LAT + 1;

  typedef enum logic [1:0] {IDLE, REFRESH, DRAIN, WAIT} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [AW:0]             pos_q, pos_d, len_q, len_d, eff_len;
  logic                    loop_q, loop_d;
  logic [6:0]              lut_code_q, lut_code_d;
  logic [6:0]              mem_q [MSG_DEPTH];
  logic [TD-1:0]           tag_v_q, tag_v_d;
  logic [DW-1:0]           tag_q [TD];
  logic [DW-1:0]           tag_d [TD];
  logic [6:0]              shadow_q [NUM_DIGITS];
  logic [6:0]              shadow_d [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic                    fv_q, fv_d, done_q, done_d;
  logic [SW-1:0]           idx;
  logic                    cap, last_cap;

  // Digit tags travel alongside each code so the returning pattern lands in the right shadow.
  always_comb begin
    eff_len  = (msg_len > (AW+1)'(MSG_DEPTH)) ? (AW+1)'(MSG_DEPTH) : msg_len;
    idx      = SW'(pos_q) + SW'(cnt_q);
    cap      = tag_v_q[TD-1];
    last_cap = cap && (tag_q[TD-1] == DW'(NUM_DIGITS-1));
    shadow_d = shadow_q;
    if (cap) shadow_d[tag_q[TD-1]] = lut_seg;
    tag_v_d  = TD'(tag_v_q << 1) | TD'(state_q == REFRESH);
    tag_d[0] = DW'(cnt_q);
    for (int i = 1; i < TD; i++) tag_d[i] = tag_q[i-1];
    seg_d = seg_q;
    if (state_q == DRAIN && last_cap && !stop)
      for (int d = 0; d < NUM_DIGITS; d++) seg_d[7*d +: 7] = shadow_d[d];
    state_d    = state_q;
    cnt_d      = cnt_q;
    pos_d      = pos_q;
    len_d      = len_q;
    loop_d     = loop_q;
    lut_code_d = lut_code_q;
    fv_d       = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (start && !stop && eff_len != '0) begin
        state_d = REFRESH;
        cnt_d   = '0;
        pos_d   = '0;
        len_d   = eff_len;
        loop_d  = loop;
      end
      REFRESH: begin
        lut_code_d = (idx < SW'(len_q)) ? mem_q[idx[AW-1:0]] : 7'd0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CW'(NUM_DIGITS-1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: if (last_cap) begin
        state_d = WAIT;
        fv_d    = 1'b1;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SCROLL_DIV-1)) begin
          cnt_d = '0;
          if (pos_q < len_q) begin
            pos_d   = pos_q + 1'b1;
            state_d = REFRESH;
          end else if (loop_q) begin
            pos_d   = '0;
            state_d = REFRESH;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      fv_d    = 1'b0;
      done_d  = 1'b0;
      tag_v_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pos_q      <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      lut_code_q <= '0;
      tag_v_q    <= '0;
      seg_q      <= '1;
      fv_q       <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < MSG_DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < TD; i++) tag_q[i] <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      lut_code_q <= lut_code_d;
      tag_v_q    <= tag_v_d;
      tag_q      <= tag_d;
      shadow_q   <= shadow_d;
      seg_q      <= seg_d;
      fv_q       <= fv_d;
      done_q     <= done_d;
      if (wr_en && state_q == IDLE) mem_q[wr_addr] <= wr_code;
    end
  end

  assign lut_code    = lut_code_q;
  assign digit_seg   = seg_q;
  assign frame_valid = fv_q;
  assign done        = done_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_text_scroll_ctrl.sv
// tb_text_scroll_ctrl: checks frames, timing, abort, reset and buffer rules of text_scroll_ctrl
// against a frame model computed from message contents and scroll position.
module tb_text_scroll_ctrl;
  localparam int N = 4, D = 16, SD = 4, LL = 1;
  localparam int FLAT = N + LL + 1;
  localparam int PER  = FLAT + SD;

  logic        clk = 0, rst_n = 0, wr_en = 0, loop = 0, start = 0, stop = 0;
  logic [3:0]  wr_addr = 0;
  logic [6:0]  wr_code = 0;
  logic [4:0]  msg_len = 0;
  logic [6:0]  lut_code;
  logic [6:0]  lut_seg = 7'h7F;
  logic [27:0] digit_seg;
  logic        frame_valid, busy, done;
  int          checks = 0, errors = 0, cyc = 0, fv_cnt = 0, done_cnt = 0;
  logic [6:0]  mm [D];

  typedef struct { int len; bit st; bit sp; bit eb; } vec_t;
  vec_t tbl [6];

  text_scroll_ctrl #(.NUM_DIGITS(N), .MSG_DEPTH(D), .SCROLL_DIV(SD), .LUT_LAT(LL)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
    .msg_len(msg_len), .loop(loop), .start(start), .stop(stop), .lut_code(lut_code),
    .lut_seg(lut_seg), .digit_seg(digit_seg), .frame_valid(frame_valid), .busy(busy), .done(done));

  function automatic logic [6:0] lut_fn(input logic [6:0] c);
    case (c)
      7'd0:  return 7'h7F;
      7'd1:  return 7'h40;
      7'd2:  return 7'h73;
      7'd3:  return 7'h24;
      7'd4:  return 7'h21;
      7'd5:  return 7'h12;
      7'd52: return 7'h46;
      7'd53: return 7'h41;
      default: return (c > 7'd62) ? 7'h7F : (c ^ 7'h2A);
    endcase
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    lut_seg <= lut_fn(lut_code);
  end
  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (done) done_cnt++;
  end

  function automatic logic [27:0] frame(input int p, input int l);
    logic [27:0] f;
    for (int d = 0; d < N; d++) f[7*d +: 7] = lut_fn((p + d < l) ? mm[p + d] : 7'd0);
    return f;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int c, input bit upd);
    wr_en = 1; wr_addr = 4'(a); wr_code = 7'(c);
    tick();
    wr_en = 0;
    if (upd) mm[a] = 7'(c);
  endtask

  task automatic go(input int len, input bit lp, output int t0);
    msg_len = 5'(len); loop = lp; start = 1;
    tick();
    start = 0;
    t0 = cyc;
  endtask

  task automatic halt();
    stop = 1;
    tick();
    stop = 0;
    chk("halt_busy", busy, 0);
  endtask

  task automatic wait_fv(input int t0, input int k, input logic [27:0] exp, input string nm);
    int n = 0;
    do begin tick(); n++; end while (!frame_valid && n < 40);
    if (!frame_valid) chk({nm, "_timeout"}, 0, 1);
    else begin
      chk({nm, "_time"}, cyc - t0, FLAT + k * PER);
      chk(nm, digit_seg, exp);
    end
  endtask

  task automatic run_full(input int len, input bit wr_mid, input string nm);
    int t0, n, le, fv0, dc0;
    le = (len > D) ? D : len;
    fv0 = fv_cnt; dc0 = done_cnt;
    go(len, 0, t0);
    for (int k = 0; k <= le; k++) begin
      wait_fv(t0, k, frame(k, le), nm);
      if (k == 0 && wr_mid) wr(1, 9, 0);
    end
    n = 0;
    do begin tick(); n++; end while (!done && n < 30);
    chk({nm, "_done_time"}, cyc - t0, FLAT + le * PER + SD);
    tick();
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_blank_hold"}, digit_seg, 28'hFFFFFFF);
    chk({nm, "_done_cnt"}, done_cnt - dc0, 1);
    chk({nm, "_fv_cnt"}, fv_cnt - fv0, le + 1);
  endtask

  initial begin
    int t0, fc, dc;
    for (int i = 0; i < D; i++) mm[i] = 0;
    tbl[0] = '{0, 1, 0, 0};
    tbl[1] = '{5, 1, 1, 0};
    tbl[2] = '{5, 0, 0, 0};
    tbl[3] = '{20, 1, 0, 1};
    tbl[4] = '{16, 1, 0, 1};
    tbl[5] = '{1, 1, 0, 1};
    tick(); tick();
    chk("rst_seg", digit_seg, 28'hFFFFFFF);
    chk("rst_busy", busy, 0);
    chk("rst_lut_code", lut_code, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_done", done, 0);
    rst_n = 1;
    tick();

    for (int i = 0; i < 5; i++) wr(i, i + 1, 1);
    run_full(5, 1, "msg5");

    go(5, 0, t0);
    wait_fv(t0, 0, {7'h21, 7'h24, 7'h73, 7'h40}, "frame0_const");
    halt();

    dc = done_cnt;
    go(5, 1, t0);
    for (int k = 0; k <= 6; k++) begin
      wait_fv(t0, k, frame(k % 6, 5), "loop");
      if (k == 0) begin
        msg_len = 2; start = 1;
        tick();
        start = 0;
      end
    end
    chk("loop_no_done", done_cnt - dc, 0);
    halt();

    wr(0, 52, 1); wr(1, 53, 1);
    go(2, 0, t0);
    wait_fv(t0, 0, {7'h7F, 7'h7F, 7'h41, 7'h46}, "wide_m");
    halt();
    wr(0, 1, 1); wr(1, 2, 1);

    go(5, 0, t0);
    wait_fv(t0, 0, frame(0, 5), "stop_f0");
    wait_fv(t0, 1, frame(1, 5), "stop_f1");
    while (cyc < t0 + 2 * PER + 2) tick();
    fc = fv_cnt;
    stop = 1;
    tick();
    stop = 0;
    chk("stop_busy", busy, 0);
    chk("stop_fv", frame_valid, 0);
    repeat (12) tick();
    chk("stop_no_frame", fv_cnt - fc, 0);
    chk("stop_hold", digit_seg, frame(1, 5));
    go(5, 0, t0);
    wait_fv(t0, 0, frame(0, 5), "restart");
    halt();

    foreach (tbl[i]) begin
      msg_len = 5'(tbl[i].len); start = tbl[i].st; stop = tbl[i].sp;
      tick();
      start = 0; stop = 0;
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
      if (busy) halt();
    end

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < D; i++) wr(i, $urandom_range(0, 127), 1);
      run_full($urandom_range(1, 24), 0, $sformatf("rand%0d", r));
    end

    for (int i = 0; i < 5; i++) wr(i, i + 1, 1);
    go(5, 0, t0);
    wait_fv(t0, 0, frame(0, 5), "pre_rst");
    tick(); tick();
    rst_n = 0;
    #1;
    chk("arst_seg", digit_seg, 28'hFFFFFFF);
    chk("arst_busy", busy, 0);
    chk("arst_lut_code", lut_code, 0);
    tick();
    rst_n = 1;
    for (int i = 0; i < D; i++) mm[i] = 0;
    tick();
    go(5, 0, t0);
    wait_fv(t0, 0, frame(0, 5), "post_rst_f0");
    wait_fv(t0, 1, frame(1, 5), "post_rst_f1");
    halt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
